traffic_phase_scheduler: RTL and testbench

- Sequences the intersection's traffic-light phases: straight and left-turn green/yellow phases for the N-S and E-W axes.
- Produces the phase state that drives the LED module and per-axis remaining-seconds counts for the digit display.
- Handles mode keys: all-red hold, night flash, phase freeze and green skip.
- Replaces the free-running state transition logic as the single timing authority for one intersection.

---
 rtl/traffic_phase_scheduler.sv | 156 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer for one intersection: 1 s prescaler, eight-phase countdown,
// mode keys (all-red hold, night flash, freeze, skip) and per-axis remaining time.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned G_TIME   = 27,
  parameter int unsigned L_TIME   = 15,
  parameter int unsigned Y_TIME   = 3,
  parameter int unsigned AR_TIME  = 2,
  parameter int unsigned SKIP_MIN = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key,
  output logic [3:0] state,
  output logic [9:0] ns_time,
  output logic [9:0] ew_time,
  output logic       tick,
  output logic       phase_start
);

  typedef enum logic [3:0] {
    NS_G      = 4'd0,
    NS_Y      = 4'd1,
    NS_L      = 4'd2,
    NS_LY     = 4'd3,
    EW_G      = 4'd4,
    EW_Y      = 4'd5,
    EW_L      = 4'd6,
    EW_LY     = 4'd7,
    ALL_RED   = 4'd8,
    FLASH_ON  = 4'd9,
    FLASH_OFF = 4'd10
  } phase_e;

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]     G_CNT     = 8'(G_TIME);
  localparam logic [7:0]     L_CNT     = 8'(L_TIME);
  localparam logic [7:0]     Y_CNT     = 8'(Y_TIME);
  localparam logic [7:0]     AR_CNT    = 8'(AR_TIME);
  localparam logic [7:0]     SKIP_CNT  = 8'(SKIP_MIN);
  localparam logic [9:0]     NS_TOTAL  = 10'(G_TIME + Y_TIME + L_TIME + Y_TIME);
  localparam logic [9:0]     REST_G    = 10'(Y_TIME + L_TIME + Y_TIME);
  localparam logic [9:0]     REST_Y    = 10'(L_TIME + Y_TIME);
  localparam logic [9:0]     REST_L    = 10'(Y_TIME);

  logic [PW-1:0] presc_q;
  phase_e        phase_q, phase_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    key_q;
  logic          skip_q;
  logic [9:0]    ns_d, ew_d;
  logic          wrap, tick_ok, skip_ok, is_flash, is_green;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return NS_L;
      NS_L:    return NS_LY;
      NS_LY:   return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return EW_L;
      EW_L:    return EW_LY;
      default: return NS_G;
    endcase
  endfunction

  function automatic logic [7:0] dur_of(input phase_e p);
    case (p)
      NS_G, EW_G: return G_CNT;
      NS_L, EW_L: return L_CNT;
      ALL_RED:    return AR_CNT;
      default:    return Y_CNT;
    endcase
  endfunction

  // A tick that coincides with any change on key[2:0] is consumed by the key action.
  assign wrap     = (presc_q == PRESC_MAX);
  assign tick_ok  = wrap && (key[2:0] == key_q);
  assign is_flash = (phase_q == FLASH_ON) || (phase_q == FLASH_OFF);
  assign is_green = (phase_q == NS_G) || (phase_q == NS_L) ||
                    (phase_q == EW_G) || (phase_q == EW_L);
  assign skip_ok  = key[3] && !skip_q && is_green && (cnt_q > SKIP_CNT);
  assign state    = phase_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc_q     <= '0;
      phase_q     <= ALL_RED;
      cnt_q       <= AR_CNT;
      key_q       <= '0;
      skip_q      <= 1'b0;
      tick        <= 1'b0;
      phase_start <= 1'b0;
      ns_time     <= 10'(AR_TIME);
      ew_time     <= 10'(AR_TIME) + NS_TOTAL;
    end else begin
      presc_q     <= wrap ? '0 : presc_q + 1'b1;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      key_q       <= key[2:0];
      skip_q      <= key[3];
      tick        <= wrap;
      phase_start <= (phase_d != phase_q);
      ns_time     <= ns_d;
      ew_time     <= ew_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (key[0]) begin
      phase_d = ALL_RED;
      cnt_d   = AR_CNT;
    end else if (key[1]) begin
      if (!is_flash)
        phase_d = FLASH_ON;
      else if (tick_ok)
        phase_d = (phase_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
    end else if (is_flash) begin
      phase_d = ALL_RED;
      cnt_d   = AR_CNT;
    end else if (key[2]) begin
      phase_d = phase_q;
    end else if (skip_ok) begin
      cnt_d = SKIP_CNT;
    end else if (tick_ok) begin
      if (cnt_q == 8'd1) begin
        phase_d = next_phase(phase_q);
        cnt_d   = dur_of(next_phase(phase_q));
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // Times are derived from the next state so they land together with state/cnt.
  always_comb begin
    ns_d = '0;
    ew_d = '0;
    case (phase_d)
      NS_G:    begin ns_d = 10'(cnt_d); ew_d = 10'(cnt_d) + REST_G;   end
      NS_Y:    begin ns_d = 10'(cnt_d); ew_d = 10'(cnt_d) + REST_Y;   end
      NS_L:    begin ns_d = 10'(cnt_d); ew_d = 10'(cnt_d) + REST_L;   end
      NS_LY:   begin ns_d = 10'(cnt_d); ew_d = 10'(cnt_d);            end
      EW_G:    begin ew_d = 10'(cnt_d); ns_d = 10'(cnt_d) + REST_G;   end
      EW_Y:    begin ew_d = 10'(cnt_d); ns_d = 10'(cnt_d) + REST_Y;   end
      EW_L:    begin ew_d = 10'(cnt_d); ns_d = 10'(cnt_d) + REST_L;   end
      EW_LY:   begin ew_d = 10'(cnt_d); ns_d = 10'(cnt_d);            end
      ALL_RED: begin ns_d = 10'(cnt_d); ew_d = 10'(cnt_d) + NS_TOTAL; end
      default: begin ns_d = '0;         ew_d = '0;                    end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed plus randomized bench for traffic_phase_scheduler against a
// phase-table reference model updated once per clock edge.
module tb_traffic_phase_scheduler;

  localparam int TD   = 4;
  localparam int AR   = 2;
  localparam int SKIP = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] key     = '0;
  logic [3:0] state;
  logic [9:0] ns_time, ew_time;
  logic       tick, phase_start;

  traffic_phase_scheduler #(
    .TICK_DIV (TD),
    .G_TIME   (27),
    .L_TIME   (15),
    .Y_TIME   (3),
    .AR_TIME  (AR),
    .SKIP_MIN (SKIP)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key         (key),
    .state       (state),
    .ns_time     (ns_time),
    .ew_time     (ew_time),
    .tick        (tick),
    .phase_start (phase_start)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_miss = 0;

  int dur [8] = '{27, 3, 15, 3, 27, 3, 15, 3};
  int m_presc, m_phase, m_cnt;
  bit m_tick, m_ps, m_k3q;
  bit [2:0] m_kq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] k);
    int  prev;
    bit  wrap, tick_ok, skip_edge;
    if (r) begin
      m_presc = 0; m_phase = 8; m_cnt = AR;
      m_tick = 0; m_ps = 0; m_kq = '0; m_k3q = 0;
    end else begin
      wrap      = (m_presc == TD - 1);
      tick_ok   = wrap && (k[2:0] == m_kq);
      skip_edge = k[3] && !m_k3q;
      prev      = m_phase;
      if (k[0]) begin
        m_phase = 8; m_cnt = AR;
      end else if (k[1]) begin
        if (m_phase < 9) m_phase = 9;
        else if (tick_ok) m_phase = (m_phase == 9) ? 10 : 9;
      end else if (m_phase >= 9) begin
        m_phase = 8; m_cnt = AR;
      end else if (k[2]) begin
        m_cnt = m_cnt;
      end else if (skip_edge && m_phase < 8 && (m_phase % 2) == 0 && m_cnt > SKIP) begin
        m_cnt = SKIP;
      end else if (tick_ok) begin
        if (m_cnt == 1) begin
          m_phase = (m_phase == 8) ? 0 : (m_phase + 1) % 8;
          m_cnt   = dur[m_phase];
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      m_ps    = (m_phase != prev);
      m_tick  = wrap;
      m_presc = wrap ? 0 : m_presc + 1;
      m_kq    = k[2:0];
      m_k3q   = k[3];
    end
  endtask

  task automatic exp_times(output int ns, output int ew);
    int rest;
    if (m_phase >= 9) begin
      ns = 0; ew = 0;
    end else if (m_phase == 8) begin
      ns = m_cnt; ew = m_cnt + 48;
    end else begin
      rest = 0;
      for (int i = m_phase % 4 + 1; i < 4; i++) rest += dur[i];
      if (m_phase < 4) begin ns = m_cnt; ew = m_cnt + rest; end
      else             begin ew = m_cnt; ns = m_cnt + rest; end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] k);
    int ens, eew;
    sys_rst = r;
    key     = k;
    @(posedge sys_clk);
    model_edge(r, k);
    #1;
    exp_times(ens, eew);
    check("state",       32'(state),       32'(m_phase));
    check("ns_time",     32'(ns_time),     32'(ens));
    check("ew_time",     32'(ew_time),     32'(eew));
    check("tick",        32'(tick),        32'(m_tick));
    check("phase_start", 32'(phase_start), 32'(m_ps));
  endtask

  task automatic steps(input int n, input logic [3:0] k);
    for (int i = 0; i < n; i++) step(1'b0, k);
  endtask

  task automatic run_until(input int target);
    int budget = 600;
    while (m_phase != target && budget > 0) begin
      step(1'b0, 4'b0000);
      budget--;
    end
    check("reach_phase", 32'(state), 32'(target));
  endtask

  function automatic bit flip(input bit cur, input int on_rate, input int off_rate);
    if (cur) return ($urandom_range(0, off_rate - 1) == 0) ? 1'b0 : 1'b1;
    return ($urandom_range(0, on_rate - 1) == 0) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    int saved_ew, nticks;
    logic [3:0] kk;

    // Reset and first cycle through the sequence
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    check("rst_state", 32'(state),   32'd8);
    check("rst_ns",    32'(ns_time), 32'd2);
    check("rst_ew",    32'(ew_time), 32'd50);
    check("rst_tick",  32'(tick),    32'd0);
    steps(8, 4'b0000);
    check("first_nsg",    32'(state),       32'd0);
    check("first_nsg_ps", 32'(phase_start), 32'd1);
    check("first_nsg_ns", 32'(ns_time),     32'd27);
    check("first_nsg_ew", 32'(ew_time),     32'd48);
    steps(96 * TD, 4'b0000);
    check("cycle_nsg",    32'(state),       32'd0);
    check("cycle_nsg_ps", 32'(phase_start), 32'd1);

    // Skip in NS_G at cnt=20, then ignored in NS_Y
    steps(7 * TD, 4'b0000);
    check("pre_skip_ns", 32'(ns_time), 32'd20);
    step(1'b0, 4'b1000);
    check("skip_ns", 32'(ns_time), 32'd5);
    steps(19, 4'b0000);
    check("skip_to_nsy", 32'(state),   32'd1);
    check("nsy_ns",      32'(ns_time), 32'd3);
    step(1'b0, 4'b1000);
    check("skip_ign_state", 32'(state),   32'd1);
    check("skip_ign_ns",    32'(ns_time), 32'd3);
    steps(3, 4'b0000);

    // Freeze in EW_L for 10 ticks
    run_until(6);
    step(1'b0, 4'b0100);
    saved_ew = int'(ew_time);
    nticks   = int'(tick);
    for (int i = 0; i < 10 * TD - 1; i++) begin
      step(1'b0, 4'b0100);
      nticks += int'(tick);
    end
    check("frz_state", 32'(state),   32'd6);
    check("frz_ew",    32'(ew_time), 32'(saved_ew));
    check("frz_ticks", 32'(nticks),  32'd10);
    steps(3 * TD, 4'b0000);

    // Night flash entered mid-EW_G
    run_until(4);
    steps(6, 4'b0000);
    step(1'b0, 4'b0010);
    check("flash_state", 32'(state),   32'd9);
    check("flash_ns",    32'(ns_time), 32'd0);
    check("flash_ew",    32'(ew_time), 32'd0);
    steps(3 * TD, 4'b0010);
    step(1'b0, 4'b0000);
    check("unflash_state", 32'(state),   32'd8);
    check("unflash_ns",    32'(ns_time), 32'd2);
    run_until(0);

    // Hold dominates flash; dropping hold alone enters flash
    steps(30, 4'b0011);
    check("hold_state", 32'(state),   32'd8);
    check("hold_ns",    32'(ns_time), 32'd2);
    check("hold_ew",    32'(ew_time), 32'd50);
    step(1'b0, 4'b0010);
    check("hold_to_flash", 32'(state), 32'd9);
    steps(10, 4'b0010);
    steps(4, 4'b0000);

    // Reset mid-NS_L
    run_until(2);
    steps(5, 4'b0000);
    step(1'b1, 4'b0000);
    check("mid_rst_state", 32'(state),   32'd8);
    check("mid_rst_ns",    32'(ns_time), 32'd2);
    check("mid_rst_ew",    32'(ew_time), 32'd50);
    steps(3, 4'b0000);
    check("rst_no_tick_yet", 32'(tick), 32'd0);
    step(1'b0, 4'b0000);
    check("rst_first_tick", 32'(tick), 32'd1);

    // Randomized keys and occasional reset
    kk = '0;
    for (int i = 0; i < 6000; i++) begin
      kk[0] = flip(kk[0], 900, 40);
      kk[1] = flip(kk[1], 700, 60);
      kk[2] = flip(kk[2], 250, 30);
      kk[3] = flip(kk[3], 12, 3);
      step(($urandom_range(0, 2999) == 0) ? 1'b1 : 1'b0, kk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
